axi_lite_rd_arbiter: RTL and testbench

//  Two-master, one-slave AXI-lite read-channel arbiter: shares the single memory read port

---
 rtl/axi_lite_rd_arbiter_pkg.sv | 22 ++
 rtl/axi_lite_rd_arbiter_rr_arb2.sv | 30 +++
 rtl/axi_lite_rd_arbiter.sv | 126 ++++++++++++
 tb/tb_axi_lite_rd_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI-lite read arbiter.
// Holds the FSM state encoding, default bus widths and grant-index helpers.
package axi_lite_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10
    } arb_state_e;

    localparam int MEM_ADDR_BUS = 32;
    localparam int MEM_DATA_BUS = 64;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // One-hot two-way grant to master index (bit 1 set means m1).
    function automatic logic onehot_idx(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
// Two-way combinational arbiter: request pair to one-hot grant.
// Round-robin uses the caller's last_grant; fixed priority always favours m1.
module axi_lite_rd_arbiter_rr_arb2
    import axi_lite_rd_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Tie-break: the master that did not win last time, or m1 under fixed priority
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (RR_EN != 0) begin
                    gnt = (last_grant == GNT_M1) ? 2'b01 : 2'b10;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Shares one AXI-lite read port between IFU (m0) and LSU (m1).
// One outstanding read: grant is held from AR accept until the R handshake completes.
module axi_lite_rd_arbiter
    import axi_lite_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BUS,
    parameter int DATA_W = MEM_DATA_BUS,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,
    output logic              busy
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              gnt_r;
    logic              last_grant_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        arb_gnt_s;
    logic              accept_s;
    logic              sel_m0_s;
    logic              sel_m1_s;

    axi_lite_rd_arbiter_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .req        ({m1_arvalid, m0_arvalid}),
        .last_grant (last_grant_r),
        .gnt        (arb_gnt_s)
    );

    // Next-state logic for the IDLE -> ADDR -> DATA read sequence
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ARB_ADDR;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (s_arready) begin
                    state_nxt_s = ARB_DATA;
                end else begin
                    state_nxt_s = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (s_rvalid && s_rready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DATA;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // State, owner and captured address; m1 as last owner lets m0 win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ARB_IDLE;
            gnt_r        <= GNT_M0;
            last_grant_r <= GNT_M1;
            addr_r       <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r       <= arb_gnt_s[1] ? m1_araddr : m0_araddr;
                gnt_r        <= onehot_idx(arb_gnt_s);
                last_grant_r <= onehot_idx(arb_gnt_s);
            end
        end
    end

    // AR handshake and R-channel routing; the non-owner sees an idle, zeroed channel
    always_comb begin
        sel_m0_s   = (state_r == ARB_DATA) && (gnt_r == GNT_M0);
        sel_m1_s   = (state_r == ARB_DATA) && (gnt_r == GNT_M1);
        m0_arready = rst && (state_r == ARB_IDLE) && arb_gnt_s[0];
        m1_arready = rst && (state_r == ARB_IDLE) && arb_gnt_s[1];
        s_arvalid  = (state_r == ARB_ADDR);
        s_araddr   = addr_r;
        busy       = (state_r != ARB_IDLE);
        if (sel_m0_s) begin
            s_rready = m0_rready;
        end else if (sel_m1_s) begin
            s_rready = m1_rready;
        end else begin
            s_rready = 1'b0;
        end
        m0_rvalid = sel_m0_s && s_rvalid;
        m1_rvalid = sel_m1_s && s_rvalid;
        m0_rdata  = sel_m0_s ? s_rdata : {DATA_W{1'b0}};
        m1_rdata  = sel_m1_s ? s_rdata : {DATA_W{1'b0}};
        m0_rresp  = sel_m0_s ? s_rresp : 2'b00;
        m1_rresp  = sel_m1_s ? s_rresp : 2'b00;
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share one stimulus set;
// use_fp selects which instance the memory model and checks observe.
module tb_axi_lite_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic [31:0] m0_araddr = 32'h0, m1_araddr = 32'h0;
    logic        m0_rready = 1'b1, m1_rready = 1'b1;
    logic        s_arready = 1'b1, s_rvalid = 1'b1;
    logic [1:0]  s_rresp = 2'b00;
    logic [63:0] s_rdata;
    logic [31:0] mem_addr = 32'h0;
    logic        use_fp = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        rr_m0_arready, rr_m0_rvalid, rr_m1_arready, rr_m1_rvalid;
    logic        rr_s_arvalid, rr_s_rready, rr_busy;
    logic [63:0] rr_m0_rdata, rr_m1_rdata;
    logic [1:0]  rr_m0_rresp, rr_m1_rresp;
    logic [31:0] rr_s_araddr;
    logic        fp_m0_arready, fp_m0_rvalid, fp_m1_arready, fp_m1_rvalid;
    logic        fp_s_arvalid, fp_s_rready, fp_busy;
    logic [63:0] fp_m0_rdata, fp_m1_rdata;
    logic [1:0]  fp_m0_rresp, fp_m1_rresp;
    logic [31:0] fp_s_araddr;

    logic        o_m0_arready, o_m0_rvalid, o_m1_arready, o_m1_rvalid;
    logic        o_s_arvalid, o_s_rready, o_busy;
    logic [63:0] o_m0_rdata, o_m1_rdata;
    logic [1:0]  o_m0_rresp, o_m1_rresp;
    logic [31:0] o_s_araddr;

    typedef struct packed {
        logic        mst;
        logic [63:0] data;
        logic [1:0]  resp;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(rr_m0_arready),
        .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata), .m0_rresp(rr_m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(rr_m1_arready),
        .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata), .m1_rresp(rr_m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(rr_s_arvalid), .s_araddr(rr_s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(rr_s_rready),
        .busy(rr_busy)
    );

    axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(fp_m0_arready),
        .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_rresp(fp_m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(fp_m1_arready),
        .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_rresp(fp_m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(fp_s_arvalid), .s_araddr(fp_s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(fp_s_rready),
        .busy(fp_busy)
    );

    assign o_m0_arready = use_fp ? fp_m0_arready : rr_m0_arready;
    assign o_m1_arready = use_fp ? fp_m1_arready : rr_m1_arready;
    assign o_m0_rvalid  = use_fp ? fp_m0_rvalid  : rr_m0_rvalid;
    assign o_m1_rvalid  = use_fp ? fp_m1_rvalid  : rr_m1_rvalid;
    assign o_m0_rdata   = use_fp ? fp_m0_rdata   : rr_m0_rdata;
    assign o_m1_rdata   = use_fp ? fp_m1_rdata   : rr_m1_rdata;
    assign o_m0_rresp   = use_fp ? fp_m0_rresp   : rr_m0_rresp;
    assign o_m1_rresp   = use_fp ? fp_m1_rresp   : rr_m1_rresp;
    assign o_s_arvalid  = use_fp ? fp_s_arvalid  : rr_s_arvalid;
    assign o_s_araddr   = use_fp ? fp_s_araddr   : rr_s_araddr;
    assign o_s_rready   = use_fp ? fp_s_rready   : rr_s_rready;
    assign o_busy       = use_fp ? fp_busy       : rr_busy;

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
        else return {~a, a};
    endfunction

    function automatic logic [31:0] addr_of(input int k, input int n);
        return (k != 0 ? 32'h2000_0000 : 32'h1000_0000) + 32'(n * 8);
    endfunction

    // Memory model: latch the address on the AR handshake, return data derived from it
    always @(posedge clk) begin
        if (o_s_arvalid && s_arready) mem_addr <= o_s_araddr;
    end
    assign s_rdata = mem_data(mem_addr);

    task automatic expect_rd(input logic mst, input logic [31:0] a);
        rd_exp_t e;
        e.mst = mst; e.data = mem_data(a); e.resp = s_rresp;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    // Masters re-request after each accept until n0/n1 reads are issued; R beats pop the scoreboard
    task automatic drain(input int n0, input int n1, input string tag);
        int cnt0, cnt1, cyc;
        logic acc0, acc1, hs0, hs1;
        rd_exp_t e;
        cnt0 = 0; cnt1 = 0; cyc = 0;
        m0_araddr = addr_of(0, 0); m1_araddr = addr_of(1, 0);
        m0_arvalid = (n0 > 0); m1_arvalid = (n1 > 0);
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            acc0 = m0_arvalid && o_m0_arready;
            acc1 = m1_arvalid && o_m1_arready;
            hs0 = o_m0_rvalid && m0_rready;
            hs1 = o_m1_rvalid && m1_rready;
            checks++;
            if (o_m0_arready && o_m1_arready) begin errors++; $display("FAIL %s arready_onehot: m0=%0b m1=%0b, need at most one", tag, o_m0_arready, o_m1_arready); end
            checks++;
            if (o_m0_rvalid && o_m1_rvalid) begin errors++; $display("FAIL %s rvalid_onehot: both high, need at most one", tag); end
            if (hs0 || hs1) begin
                e = exp_q.pop_front();
                checks++;
                if (hs1 !== e.mst) begin errors++; $display("FAIL %s owner: got m%0d, expected m%0d", tag, hs1, e.mst); end
                checks++;
                if ((hs1 ? o_m1_rdata : o_m0_rdata) !== e.data) begin errors++; $display("FAIL %s rdata: got %h, expected %h", tag, (hs1 ? o_m1_rdata : o_m0_rdata), e.data); end
                checks++;
                if ((hs1 ? o_m1_rresp : o_m0_rresp) !== e.resp) begin errors++; $display("FAIL %s rresp: got %b, expected %b", tag, (hs1 ? o_m1_rresp : o_m0_rresp), e.resp); end
            end
            @(posedge clk); #1;
            if (acc0) begin cnt0++; if (cnt0 < n0) m0_araddr = addr_of(0, cnt0); else m0_arvalid = 1'b0; end
            if (acc1) begin cnt1++; if (cnt1 < n1) m1_araddr = addr_of(1, cnt1); else m1_arvalid = 1'b0; end
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s timeout: %0d reads left, expected 0", tag, exp_q.size()); end
        exp_q.delete();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    endtask

    task automatic test_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h1234_5678;
        @(negedge clk); @(negedge clk);
        checks++; if (o_m0_arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b, expected 0", o_m0_arready); end
        checks++; if (o_busy !== 1'b0 || fp_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b, expected 0/0", o_busy, fp_busy); end
        checks++; if (o_s_arvalid !== 1'b0 || o_s_araddr !== 32'h0) begin errors++; $display("FAIL reset_ar: got %b %h, expected 0 0", o_s_arvalid, o_s_araddr); end
        checks++; if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 64'h0) begin errors++; $display("FAIL reset_r: got %b %h, expected 0 0", o_m0_rvalid, o_m0_rdata); end
        checks++; if (o_s_rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b, expected 0", o_s_rready); end
        m0_arvalid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1; m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        @(negedge clk);
        checks++; if (o_m0_arready !== 1'b1 || o_m1_arready !== 1'b0) begin errors++; $display("FAIL single_c0_arready: got %b/%b, expected 1/0", o_m0_arready, o_m1_arready); end
        checks++; if (o_s_arvalid !== 1'b0) begin errors++; $display("FAIL single_c0_sarvalid: got %b, expected 0", o_s_arvalid); end
        @(posedge clk); #1; m0_arvalid = 1'b0;
        @(negedge clk);
        checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL single_c1_ar: got %b %h, expected 1 80000000", o_s_arvalid, o_s_araddr); end
        checks++; if (o_m0_rvalid !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL single_c1_state: rvalid %b busy %b, expected 0 1", o_m0_rvalid, o_busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL single_c2_r: got %b %h, expected 1 1122334455667788", o_m0_rvalid, o_m0_rdata); end
        checks++; if (o_m1_rvalid !== 1'b0 || o_m1_rdata !== 64'h0) begin errors++; $display("FAIL single_c2_m1: got %b %h, expected 0 0", o_m1_rvalid, o_m1_rdata); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0 || o_m0_rvalid !== 1'b0) begin errors++; $display("FAIL single_c3_idle: busy %b rvalid %b, expected 0 0", o_busy, o_m0_rvalid); end
    endtask

    task automatic test_round_robin();
        use_fp = 1'b0;
        do_reset();
        expect_rd(1'b0, addr_of(0, 0));
        expect_rd(1'b1, addr_of(1, 0));
        expect_rd(1'b0, addr_of(0, 1));
        expect_rd(1'b1, addr_of(1, 1));
        drain(2, 2, "rr");
    endtask

    task automatic test_fixed_priority();
        use_fp = 1'b1;
        expect_rd(1'b1, addr_of(1, 0));
        expect_rd(1'b1, addr_of(1, 1));
        expect_rd(1'b0, addr_of(0, 0));
        drain(1, 2, "fixed");
        use_fp = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        a = 32'h3000_0040;
        @(posedge clk); #1; s_arready = 1'b0; m1_araddr = a; m1_arvalid = 1'b1;
        @(negedge clk);
        checks++; if (o_m1_arready !== 1'b1) begin errors++; $display("FAIL wait_accept: got %b, expected 1", o_m1_arready); end
        @(posedge clk); #1; m1_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (o_s_arvalid !== 1'b1 || o_s_araddr !== a) begin errors++; $display("FAIL wait_addr_hold[%0d]: got %b %h, expected 1 %h", i, o_s_arvalid, o_s_araddr, a); end
            checks++; if (o_s_rready !== 1'b0 || o_m1_rvalid !== 1'b0) begin errors++; $display("FAIL wait_r_ignored[%0d]: rready %b rvalid %b, expected 0 0", i, o_s_rready, o_m1_rvalid); end
            @(posedge clk); #1;
        end
        s_arready = 1'b1; m1_rready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_s_rready !== 1'b0 || o_m1_rvalid !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL wait_stall[%0d]: rready %b rvalid %b busy %b, expected 0 1 1", i, o_s_rready, o_m1_rvalid, o_busy); end
            @(posedge clk); #1;
        end
        m1_rready = 1'b1;
        @(negedge clk);
        checks++; if (o_s_rready !== 1'b1 || o_m1_rdata !== mem_data(a)) begin errors++; $display("FAIL wait_release: rready %b data %h, expected 1 %h", o_s_rready, o_m1_rdata, mem_data(a)); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL wait_done_busy: got %b, expected 0", o_busy); end
    endtask

    task automatic test_reset_in_data();
        @(posedge clk); #1; m0_araddr = 32'h4000_0010; m0_arvalid = 1'b1; m0_rready = 1'b0;
        @(posedge clk); #1; m0_arvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (o_m0_rvalid !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL rstdata_pre: rvalid %b busy %b, expected 1 1", o_m0_rvalid, o_busy); end
        #2; rst = 1'b0; #1;
        checks++; if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 64'h0 || o_busy !== 1'b0) begin errors++; $display("FAIL rstdata_zero: rvalid %b data %h busy %b, expected 0 0 0", o_m0_rvalid, o_m0_rdata, o_busy); end
        checks++; if (o_s_arvalid !== 1'b0 || o_s_rready !== 1'b0) begin errors++; $display("FAIL rstdata_s: arvalid %b rready %b, expected 0 0", o_s_arvalid, o_s_rready); end
        @(posedge clk); #1; rst = 1'b1; m0_rready = 1'b1;
        @(negedge clk);
        checks++; if (o_m0_rvalid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rstdata_stale: rvalid %b busy %b, expected 0 0", o_m0_rvalid, o_busy); end
        expect_rd(1'b0, addr_of(0, 0));
        drain(1, 0, "after_reset");
    endtask

    task automatic test_error_resp();
        s_rresp = 2'b10;
        expect_rd(1'b1, addr_of(1, 0));
        drain(0, 1, "slverr");
        s_rresp = 2'b00;
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL slverr_idle: busy %b, expected 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_wait_states();
        test_reset_in_data();
        test_error_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
